fc0_act_buffer: RTL and testbench
=================================

# fc0_act_buffer

Ping-pong activation buffer between `fc0_layer` and the `fc1` scheduler. It captures the ReLU'd fc0 outputs, which arrive as `BEAT_WIDTH` lanes per beat with per-lane neuron ids, and reassembles each complete activation vector in neuron order. It then streams that vector to fc1 two activations per cycle, matching fc1's `activations_i[1:0]` / `valid_i` port, under a ready/valid handshake. Two banks let fc0 fill the next vector while the previous one drains.

## Interface
Parameters:
- `PREC`, 18, activation width (matches `` `PREC``).
- `TOTAL`, 64, fc0 neurons per vector. Must be even and a multiple of `BEAT_WIDTH`.
- `BEAT_WIDTH`, 8, lanes per input beat (matches `` `FC0_NEURONS``).
- `ID_W`, `$clog2(TOTAL)`, neuron-id width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `act_i` input `BEAT_WIDTH*PREC`: activation lanes from fc0.
- `id_i` input `BEAT_WIDTH*ID_W`: neuron id per lane.
- `valid_i` input 1: beat valid. There is no backpressure; fc0 cannot stall.
- `act_o` output `2*PREC`: `[0]` = neuron 2k, `[1]` = neuron 2k+1.
- `valid_o` output 1: `act_o` holds a pair.
- `ready_i` input 1: the consumer accepts the pair when `valid_o & ready_i`.
- `busy_o` output 1: any bank full, or streaming in progress.
- `frame_done_o` output 1: one-cycle pulse in the cycle after the last pair of a vector is accepted.

## Operation
- Storage: two banks of `TOTAL` x `PREC`. Per-bank flag `full[b]`. Pointers `wr_bank` and `rd_bank`.
- Capture:
  - On `valid_i`, if `!full[wr_bank]`, write lane j to `bank[wr_bank][id_i[j]]`, then increment `beat_cnt`.
  - When `beat_cnt == TOTAL/BEAT_WIDTH-1` and a beat is accepted: set `full[wr_bank]`, toggle `wr_bank`, clear `beat_cnt`.
  - Completion is counted by beats, not by ids. Duplicate ids overwrite; locations never written keep stale data.
- Overflow: if `valid_i` arrives while `full[wr_bank]` is set (both banks full), the beat is dropped. There are no writes and `beat_cnt` holds.
- Read FSM:
  - IDLE -> LOAD when `full[rd_bank]`.
  - LOAD: register the pair at `rd_ptr=0`, assert `valid_o`, go to STREAM.
  - STREAM, on accept: if `rd_ptr == TOTAL-2`, clear `valid_o`, clear `full[rd_bank]`, toggle `rd_bank`, pulse `frame_done_o`, go to IDLE. Otherwise advance `rd_ptr += 2` and load the next pair.
  - STREAM with `!ready_i`: hold `act_o` and `valid_o` unchanged.
- Simultaneous events:
  - Capture may set `full[wr_bank]` in the same cycle that the read side clears `full[rd_bank]`. The banks differ, so both updates apply.
  - A beat arriving in the cycle `full[rd_bank]` clears is not accepted into that bank when `wr_bank == rd_bank` and it was full at the sampling edge. It is dropped; overflow semantics apply.
- `busy_o = full[0] | full[1] | (state != IDLE)`.

## Timing
- Reset values:
  - `act_o=0`, `valid_o=0`, `busy_o=0`, `frame_done_o=0`.
  - `full=0`, `beat_cnt=0`, `wr_bank=rd_bank=0`, `rd_ptr=0`, FSM in IDLE.
- Reset mid-stream discards both banks immediately.
- Last beat accepted at edge T. Then `full` is visible in cycle T+1, LOAD runs in T+1, and the first `valid_o` is in T+2.
- With `ready_i` held high, one pair is transferred per cycle. A full vector takes `TOTAL/2` cycles, and `frame_done_o` is in the cycle after the last accept.
- A new vector can be loaded no earlier than 1 cycle (IDLE) after `frame_done_o`.

## Configuration
- `FC0_ACT_BUF_STATUS_EN` defined:
  - Adds output `ovf_o` (1 bit): sticky, set on any dropped beat, cleared only by `rst`.
  - Adds output `drop_cnt_o` (16 bits): saturating count of dropped beats.
- Undefined: both ports are absent and dropped beats are silent. Data-path behaviour is identical in both builds.

## Structure
- Shared package `fc_pkg`:
  - FSM state enum `{IDLE, LOAD, STREAM}`.
  - Pair typedef `logic [1:0][PREC-1:0]`.
  - Default `TOTAL`/`BEAT_WIDTH` constants, tied to `sys_defs.vh` values.
- One sub-module: `act_bank`, one `TOTAL` x `PREC` bank with a `BEAT_WIDTH`-lane id-addressed write port and a 2-wide aligned read port. It is instantiated twice. Everything else stays in the top module.

## Test plan
- Single vector, `ready_i=1`: 8 beats with ids `8k..8k+7`, data = id. Expect 32 pairs `(0,1),(2,3)...(62,63)`; first `valid_o` 2 cycles after the last beat; `frame_done_o` 1 cycle after pair `(62,63)`.
- Permuted ids: beats arrive in reverse order, with ids scrambled within each beat. Expect output still in ascending neuron order.
- Backpressure: drop `ready_i` for 3 cycles at pair `(10,11)`. Expect `act_o`/`valid_o` held constant, no pair lost or duplicated, 32 pairs total.
- Ping-pong: vector B starts immediately after vector A. Expect A to stream while B fills, then B to stream with no intervening beat dropped.
- Overflow (`FC0_ACT_BUF_STATUS_EN`): hold `ready_i=0` and send 3 vectors. Expect the third vector's 8 beats dropped, `ovf_o=1`, `drop_cnt_o=8`; after release, vectors 1 and 2 stream intact.
- Async reset asserted mid-STREAM at pair `(20,21)`. Expect `valid_o=0` and `busy_o=0` immediately, and no output after release until a new full vector arrives.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared fc-datapath definitions: read FSM states, activation pair type and
// default geometry tied to the sys_defs.vh values.
package fc_pkg;

    localparam int FC_PREC       = 18;  // `PREC
    localparam int FC_TOTAL      = 64;
    localparam int FC_BEAT_WIDTH = 8;   // `FC0_NEURONS

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM
    } rd_state_t;

    typedef logic [1:0][FC_PREC-1:0] act_pair_t;

endpackage

// File: rtl/act_bank.sv
// One TOTAL x PREC activation bank: BEAT_WIDTH-lane id-addressed write port,
// 2-wide aligned asynchronous read port (pair index selects neurons 2k, 2k+1).
module act_bank
    import fc_pkg::*;
#(
    parameter int PREC       = FC_PREC,
    parameter int TOTAL      = FC_TOTAL,
    parameter int BEAT_WIDTH = FC_BEAT_WIDTH,
    parameter int ID_W       = $clog2(TOTAL)
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [BEAT_WIDTH*PREC-1:0] wdata,
    input  logic [BEAT_WIDTH*ID_W-1:0] wid,
    input  logic [ID_W-2:0]            rpair,
    output logic [1:0][PREC-1:0]       rdata
);

    logic [PREC-1:0] mem [TOTAL];

    // Duplicate ids within one beat resolve to the highest lane.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned j = 0; j < BEAT_WIDTH; j++) begin
                mem[wid[j*ID_W +: ID_W]] <= wdata[j*PREC +: PREC];
            end
        end
    end

    always_comb begin
        rdata[0] = mem[{rpair, 1'b0}];
        rdata[1] = mem[{rpair, 1'b1}];
    end

endmodule

// File: rtl/fc0_act_buffer.sv
// Ping-pong activation buffer between fc0_layer and the fc1 scheduler.
// Optional status outputs (ovf_o, drop_cnt_o) under `FC0_ACT_BUF_STATUS_EN.
module fc0_act_buffer
    import fc_pkg::*;
#(
    parameter int PREC       = FC_PREC,
    parameter int TOTAL      = FC_TOTAL,
    parameter int BEAT_WIDTH = FC_BEAT_WIDTH,
    parameter int ID_W       = $clog2(TOTAL)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BEAT_WIDTH*PREC-1:0] act_i,
    input  logic [BEAT_WIDTH*ID_W-1:0] id_i,
    input  logic                       valid_i,
    output logic [2*PREC-1:0]          act_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       busy_o,
    output logic                       frame_done_o
`ifdef FC0_ACT_BUF_STATUS_EN
    ,
    output logic                       ovf_o,
    output logic [15:0]                drop_cnt_o
`endif
);

    localparam int BEATS = TOTAL / BEAT_WIDTH;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(BEATS - 1);
    localparam logic [ID_W-2:0] LAST_PAIR = (ID_W-1)'(TOTAL/2 - 1);

    logic [1:0]           full;
    logic                 wr_bank;
    logic                 rd_bank;
    logic [BC_W-1:0]      beat_cnt;
    // Pair index; the neuron read pointer is 2*rd_pair.
    logic [ID_W-2:0]      rd_pair;
    logic [ID_W-2:0]      rd_addr;
    rd_state_t            state;

    logic                 accept;
    logic                 last_beat;
    logic                 frame_end;
    logic [1:0][PREC-1:0] bank_rd [2];
    logic [1:0][PREC-1:0] pair;

    assign accept    = valid_i & ~full[wr_bank];
    assign last_beat = accept & (beat_cnt == LAST_BEAT);
    assign frame_end = (state == STREAM) & ready_i & (rd_pair == LAST_PAIR);
    assign rd_addr   = (state == LOAD) ? '0 : rd_pair + 1'b1;
    assign pair      = bank_rd[rd_bank];
    assign busy_o    = (|full) | (state != IDLE);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        act_bank #(
            .PREC       (PREC),
            .TOTAL      (TOTAL),
            .BEAT_WIDTH (BEAT_WIDTH),
            .ID_W       (ID_W)
        ) u_bank (
            .clk   (clk),
            .we    (accept & (wr_bank == 1'(b))),
            .wdata (act_i),
            .wid   (id_i),
            .rpair (rd_addr),
            .rdata (bank_rd[b])
        );
    end

    // A full set and a full clear in the same cycle always target different banks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full     <= '0;
            wr_bank  <= 1'b0;
            beat_cnt <= '0;
        end else begin
            if (accept) begin
                if (last_beat) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    beat_cnt      <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
            if (frame_end) begin
                full[rd_bank] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rd_bank      <= 1'b0;
            rd_pair      <= '0;
            act_o        <= '0;
            valid_o      <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            unique case (state)
                // Also looks at the completing beat so LOAD runs in the cycle
                // right after the final write, not one cycle later.
                IDLE: begin
                    if (full[rd_bank] | (last_beat & (wr_bank == rd_bank))) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    act_o   <= pair;
                    valid_o <= 1'b1;
                    rd_pair <= '0;
                    state   <= STREAM;
                end
                STREAM: begin
                    if (ready_i) begin
                        if (rd_pair == LAST_PAIR) begin
                            valid_o      <= 1'b0;
                            rd_bank      <= ~rd_bank;
                            rd_pair      <= '0;
                            frame_done_o <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            rd_pair <= rd_pair + 1'b1;
                            act_o   <= pair;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FC0_ACT_BUF_STATUS_EN
    logic drop;
    assign drop = valid_i & full[wr_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_o      <= 1'b0;
            drop_cnt_o <= '0;
        end else if (drop) begin
            ovf_o <= 1'b1;
            if (drop_cnt_o != '1) begin
                drop_cnt_o <= drop_cnt_o + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fc0_act_buffer.sv
// Directed bench for fc0_act_buffer: ordering, latency, backpressure,
// ping-pong, overflow and async reset; status ports under FC0_ACT_BUF_STATUS_EN.
module tb_fc0_act_buffer;

    localparam int PREC  = 18;
    localparam int TOTAL = 64;
    localparam int BW    = 8;
    localparam int ID_W  = 6;
    localparam int PAIRS = TOTAL / 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [BW*PREC-1:0] act_i;
    logic [BW*ID_W-1:0] id_i;
    logic               valid_i;
    logic [2*PREC-1:0]  act_o;
    logic               valid_o;
    logic               ready_i;
    logic               busy_o;
    logic               frame_done_o;
`ifdef FC0_ACT_BUF_STATUS_EN
    logic               ovf_o;
    logic [15:0]        drop_cnt_o;
`endif

    always #5 clk = ~clk;

    fc0_act_buffer #(
        .PREC       (PREC),
        .TOTAL      (TOTAL),
        .BEAT_WIDTH (BW),
        .ID_W       (ID_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .act_i        (act_i),
        .id_i         (id_i),
        .valid_i      (valid_i),
        .act_o        (act_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .frame_done_o (frame_done_o)
`ifdef FC0_ACT_BUF_STATUS_EN
        ,
        .ovf_o        (ovf_o),
        .drop_cnt_o   (drop_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [PREC-1:0] val(input int vec, input int id);
        return PREC'(vec * 256 + id);
    endfunction

    function automatic logic [2*PREC-1:0] exp_pair(input int vec, input int p);
        return {val(vec, 2*p + 1), val(vec, 2*p)};
    endfunction

    // Consumer-side monitor, sampled on the falling edge.
    logic [2*PREC-1:0] got_q[$];
    int cyc = 0, first_acc = 0, last_acc = 0, fd_cnt = 0, fd_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (valid_o && ready_i) begin
            if (got_q.size() == 0) first_acc = cyc;
            got_q.push_back(act_o);
            last_acc = cyc;
        end
        if (frame_done_o) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    end

    task automatic start_test();
        got_q.delete();
        fd_cnt = 0;
    endtask

    // mode 0: ascending beats, ids in lane order; mode 1: reverse beats, lanes scrambled
    task automatic send_vector(input int vec, input int mode);
        for (int k = 0; k < BW; k++) begin
            int beat;
            beat = (mode != 0) ? (BW - 1 - k) : k;
            @(posedge clk);
            #1;
            valid_i = 1'b1;
            for (int j = 0; j < BW; j++) begin
                int lid;
                lid = (mode != 0) ? beat*BW + ((j*5 + 3) % BW) : beat*BW + j;
                act_i[j*PREC +: PREC] = val(vec, lid);
                id_i[j*ID_W +: ID_W]  = ID_W'(lid);
            end
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && fd_cnt < n; i++) @(posedge clk);
        check_val("frame_count", 64'(fd_cnt), 64'(n));
        @(negedge clk);
        #1;
    endtask

    task automatic check_stream(input int vec, input int base);
        for (int p = 0; p < PAIRS; p++) begin
            logic [2*PREC-1:0] g;
            g = (base + p < got_q.size()) ? got_q[base + p] : '1;
            check_val($sformatf("v%0d_pair%0d", vec, p), 64'(g), 64'(exp_pair(vec, p)));
        end
    endtask

    task automatic wait_pair(input int vec, input int p, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (valid_o && act_o == exp_pair(vec, p)) found = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit found;
        int seen;

        rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; act_i = '0; id_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_valid", 64'(valid_o), 0);
        check_val("rst_busy", 64'(busy_o), 0);
        check_val("rst_fdone", 64'(frame_done_o), 0);
        check_val("rst_act", 64'(act_o), 0);
`ifdef FC0_ACT_BUF_STATUS_EN
        check_val("rst_ovf", 64'(ovf_o), 0);
        check_val("rst_drop", 64'(drop_cnt_o), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single vector, data = id, latency and throughput
        start_test();
        send_vector(0, 0);
        go_idle();
        @(negedge clk);
        check_val("t1_load_valid", 64'(valid_o), 0);
        check_val("t1_load_busy", 64'(busy_o), 1);
        @(negedge clk);
        check_val("t1_first_valid", 64'(valid_o), 1);
        check_val("t1_first_pair", 64'(act_o), 64'(exp_pair(0, 0)));
        wait_frames(1, 100);
        check_val("t1_npairs", 64'(got_q.size()), PAIRS);
        check_stream(0, 0);
        check_val("t1_stream_span", 64'(last_acc - first_acc), PAIRS - 1);
        check_val("t1_fdone_lag", 64'(fd_cyc - last_acc), 1);
        check_val("t1_fdone_pulse", 64'(frame_done_o), 0);
        check_val("t1_idle_busy", 64'(busy_o), 0);

        // permuted ids
        start_test();
        send_vector(1, 1);
        go_idle();
        wait_frames(1, 100);
        check_val("t2_npairs", 64'(got_q.size()), PAIRS);
        check_stream(1, 0);

        // backpressure at pair (10,11)
        start_test();
        send_vector(2, 0);
        go_idle();
        wait_pair(2, 5, found);
        check_val("t3_found", 64'(found), 1);
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("t3_hold_valid%0d", i), 64'(valid_o), 1);
            check_val($sformatf("t3_hold_act%0d", i), 64'(act_o), 64'(exp_pair(2, 5)));
        end
        ready_i = 1'b1;
        wait_frames(1, 100);
        check_val("t3_npairs", 64'(got_q.size()), PAIRS);
        check_stream(2, 0);

        // ping-pong: B fills while A drains
        start_test();
        send_vector(3, 0);
        send_vector(4, 1);
        go_idle();
        wait_frames(2, 300);
        check_val("t4_npairs", 64'(got_q.size()), 2*PAIRS);
        check_stream(3, 0);
        check_stream(4, PAIRS);
`ifdef FC0_ACT_BUF_STATUS_EN
        check_val("t4_no_ovf", 64'(ovf_o), 0);
`endif

        // overflow: third vector dropped while both banks are full
        start_test();
        ready_i = 1'b0;
        send_vector(5, 0);
        send_vector(6, 0);
        send_vector(7, 1);
        go_idle();
        repeat (3) @(negedge clk);
        check_val("t5_held_valid", 64'(valid_o), 1);
        check_val("t5_held_busy", 64'(busy_o), 1);
        check_val("t5_held_act", 64'(act_o), 64'(exp_pair(5, 0)));
`ifdef FC0_ACT_BUF_STATUS_EN
        check_val("t5_ovf", 64'(ovf_o), 1);
        check_val("t5_drop_cnt", 64'(drop_cnt_o), 8);
`endif
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        wait_frames(2, 300);
        check_val("t5_npairs", 64'(got_q.size()), 2*PAIRS);
        check_stream(5, 0);
        check_stream(6, PAIRS);
        repeat (10) @(negedge clk);
        check_val("t5_drain_valid", 64'(valid_o), 0);
        check_val("t5_drain_busy", 64'(busy_o), 0);
        check_val("t5_no_extra", 64'(got_q.size()), 2*PAIRS);

        // async reset mid-stream at pair (20,21)
        start_test();
        send_vector(8, 0);
        go_idle();
        wait_pair(8, 10, found);
        check_val("t6_found", 64'(found), 1);
        rst = 1'b1;
        #1;
        check_val("t6_rst_valid", 64'(valid_o), 0);
        check_val("t6_rst_busy", 64'(busy_o), 0);
        check_val("t6_rst_act", 64'(act_o), 0);
`ifdef FC0_ACT_BUF_STATUS_EN
        check_val("t6_rst_ovf", 64'(ovf_o), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid_o || busy_o) seen++;
        end
        check_val("t6_quiet", 64'(seen), 0);
        start_test();
        send_vector(9, 1);
        go_idle();
        wait_frames(1, 100);
        check_val("t6_npairs", 64'(got_q.size()), PAIRS);
        check_stream(9, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
